// File: rtl/instr_fetch_unit.sv
// instr_fetch_unit: credit-limited imem fetch with in-flight PC pairing, decode buffer and redirect squash.
module instr_fetch_unit #(
   parameter int XLEN = 32,
   parameter int FIFO_DEPTH = 2,
   parameter int MAX_OUTSTANDING = 2
) (
   input  logic            clk,
   input  logic            reset,
   input  logic [XLEN-1:0] pc_in,
   output logic            pc_inc,
   output logic            pc_load_en,
   output logic [XLEN-1:0] pc_load_addr,
   input  logic            redirect_valid,
   input  logic [XLEN-1:0] redirect_addr,
   output logic            imem_req_valid,
   input  logic            imem_req_ready,
   output logic [XLEN-1:0] imem_req_addr,
   input  logic            imem_rsp_valid,
   input  logic [XLEN-1:0] imem_rsp_data,
   output logic            if_valid,
   input  logic            if_ready,
   output logic [XLEN-1:0] if_instr,
   output logic [XLEN-1:0] if_pc
);
   localparam int PW = $clog2(FIFO_DEPTH);
   localparam int CW = $clog2(FIFO_DEPTH + 1);
   localparam int OW = $clog2(MAX_OUTSTANDING + 1);
   localparam int IW = MAX_OUTSTANDING > 1 ? $clog2(MAX_OUTSTANDING) : 1;
   localparam int SW = $clog2(FIFO_DEPTH + MAX_OUTSTANDING + 1);
   logic [XLEN-1:0] fifo_pc [FIFO_DEPTH];
   logic [XLEN-1:0] fifo_instr [FIFO_DEPTH];
   logic [XLEN-1:0] inflight_pc [MAX_OUTSTANDING];
   logic [PW-1:0]   wr_ptr, rd_ptr;
   logic [CW-1:0]   fifo_count;
   logic [IW-1:0]   iq_wr, iq_rd;
   logic [OW-1:0]   outstanding, drop_count;
   logic [XLEN-1:0] fetch_addr;
   logic            issue, accept, rsp_take, push, pop;
   function automatic logic [IW-1:0] nxt(input logic [IW-1:0] p);
      return (p == IW'(MAX_OUTSTANDING - 1)) ? '0 : p + 1'b1;
   endfunction
   assign fetch_addr = pc_in & ~XLEN'(3);
   // in-flight plus buffered never exceeds the buffer, so every response has a slot
   assign issue = !reset && !redirect_valid && outstanding < OW'(MAX_OUTSTANDING)
                  && SW'(outstanding) + SW'(fifo_count) < SW'(FIFO_DEPTH);
   assign accept = issue && imem_req_ready;
   assign rsp_take = imem_rsp_valid && outstanding != '0;
   assign push = rsp_take && drop_count == '0 && !redirect_valid;
   assign if_valid = !reset && fifo_count != '0 && !redirect_valid;
   assign pop = if_valid && if_ready;
   assign imem_req_valid = issue;
   assign imem_req_addr = issue ? fetch_addr : '0;
   assign pc_inc = accept;
   assign pc_load_en = redirect_valid && !reset;
   assign pc_load_addr = pc_load_en ? (redirect_addr & ~XLEN'(3)) : '0;
   assign if_instr = if_valid ? fifo_instr[rd_ptr] : '0;
   assign if_pc = if_valid ? fifo_pc[rd_ptr] : '0;
   always_ff @(posedge clk) begin
      if (reset) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         fifo_count <= '0;
         iq_wr <= '0;
         iq_rd <= '0;
         outstanding <= '0;
         drop_count <= '0;
      end else begin
         if (accept) begin
            inflight_pc[iq_wr] <= fetch_addr;
            iq_wr <= nxt(iq_wr);
         end
         if (rsp_take) iq_rd <= nxt(iq_rd);
         outstanding <= outstanding + OW'(accept) - OW'(rsp_take);
         // a response landing in the redirect cycle is squashed along with the buffer
         if (redirect_valid) begin
            drop_count <= outstanding - OW'(rsp_take);
            wr_ptr <= '0;
            rd_ptr <= '0;
            fifo_count <= '0;
         end else begin
            if (rsp_take && drop_count != '0) drop_count <= drop_count - 1'b1;
            if (push) begin
               fifo_pc[wr_ptr] <= inflight_pc[iq_rd];
               fifo_instr[wr_ptr] <= imem_rsp_data;
               wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) rd_ptr <= rd_ptr + 1'b1;
            fifo_count <= fifo_count + CW'(push) - CW'(pop);
         end
      end
   end
endmodule

// File: tb/tb_instr_fetch_unit.sv
// tb_instr_fetch_unit: directed scenarios; a monitor pops an expected {pc, instr} queue on every decode transfer.
module tb_instr_fetch_unit;
   logic        clk = 0;
   logic        reset, pc_inc, pc_load_en, redirect_valid;
   logic        imem_req_valid, imem_req_ready, imem_rsp_valid, if_valid, if_ready;
   logic [31:0] pc_in, pc_load_addr, redirect_addr, imem_req_addr, imem_rsp_data, if_instr, if_pc;
   logic [63:0] sbq [$];
   logic [31:0] mq [$];
   logic        s_inc = 0, s_ld = 0, mem_hold = 0;
   logic [31:0] s_ld_addr = 0, a;
   int          total = 0, bad = 0, inc_cnt = 0, c;

   instr_fetch_unit dut (
      .clk(clk), .reset(reset), .pc_in(pc_in), .pc_inc(pc_inc), .pc_load_en(pc_load_en),
      .pc_load_addr(pc_load_addr), .redirect_valid(redirect_valid), .redirect_addr(redirect_addr),
      .imem_req_valid(imem_req_valid), .imem_req_ready(imem_req_ready), .imem_req_addr(imem_req_addr),
      .imem_rsp_valid(imem_rsp_valid), .imem_rsp_data(imem_rsp_data), .if_valid(if_valid),
      .if_ready(if_ready), .if_instr(if_instr), .if_pc(if_pc)
   );

   always #5 clk = ~clk;

   // program counter and in-order memory (data = {addr[15:0], 16'h0013})
   always @(negedge clk) begin
      s_inc = pc_inc;
      s_ld = pc_load_en;
      s_ld_addr = pc_load_addr;
      if (imem_req_valid && imem_req_ready) mq.push_back(imem_req_addr);
      if (pc_inc) inc_cnt++;
   end
   always @(posedge clk) begin
      #2;
      if (s_ld) pc_in = s_ld_addr;
      else if (s_inc) pc_in = pc_in + 4;
      if (!mem_hold && mq.size() > 0) begin
         a = mq.pop_front();
         imem_rsp_valid = 1;
         imem_rsp_data = {a[15:0], 16'h0013};
      end else begin
         imem_rsp_valid = 0;
         imem_rsp_data = 0;
      end
   end

   always @(negedge clk) begin
      if (if_valid && if_ready) begin
         total++;
         if (sbq.size() == 0) begin
            bad++;
            $display("FAIL if_extra: got pc=%h instr=%h, want no transfer", if_pc, if_instr);
         end else if ({if_pc, if_instr} !== sbq[0]) begin
            bad++;
            $display("FAIL if_out: got pc=%h instr=%h, want pc=%h instr=%h",
                     if_pc, if_instr, sbq[0][63:32], sbq[0][31:0]);
            void'(sbq.pop_front());
         end else void'(sbq.pop_front());
      end
   end

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] want);
      total++;
      if (act !== want) begin
         bad++;
         $display("FAIL %s: got %h, want %h", name, act, want);
      end
   endtask

   task automatic next();
      @(posedge clk);
      #1;
   endtask

   task automatic expect_if(input logic [31:0] pc, input logic [31:0] instr);
      sbq.push_back({pc, instr});
   endtask

   task automatic fetch_n(input int n);
      int k2 = 0;
      imem_req_ready = 1;
      for (int k = 0; k < 60 && k2 < n; k++) begin
         #2;
         if (imem_req_valid) begin
            k2++;
            chk("pc_inc_on_accept", pc_inc, 1);
         end
         next();
      end
      imem_req_ready = 0;
      chk("accept_count", k2, n);
   endtask

   task automatic drain();
      for (int k = 0; k < 60 && sbq.size() != 0; k++) next();
      repeat (3) next();
      chk("drain", sbq.size(), 0);
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: no finish within time limit");
      $fatal(1);
   end

   initial begin
      reset = 1; pc_in = 32'h100; redirect_valid = 0; redirect_addr = 0;
      imem_req_ready = 0; imem_rsp_valid = 0; imem_rsp_data = 0; if_ready = 1;
      repeat (3) next();
      #2;
      chk("rst_req_valid", imem_req_valid, 0);
      chk("rst_pc_inc", pc_inc, 0);
      chk("rst_pc_load_en", pc_load_en, 0);
      chk("rst_if_valid", if_valid, 0);
      chk("rst_if_instr", if_instr, 0);
      chk("rst_if_pc", if_pc, 0);
      next();
      reset = 0;
      // memory stall: request held, address stable
      repeat (3) begin
         #2;
         chk("stall_req_valid", imem_req_valid, 1);
         chk("stall_req_addr", imem_req_addr, 32'h100);
         chk("stall_pc_inc", pc_inc, 0);
         next();
      end
      expect_if(32'h100, 32'h01000013);
      expect_if(32'h104, 32'h01040013);
      fetch_n(2);
      drain();
      chk("inc_pulses", inc_cnt, 2);
      // decode stall: buffer fills to depth, then issue stops
      if_ready = 0;
      expect_if(32'h108, 32'h01080013);
      expect_if(32'h10c, 32'h010c0013);
      expect_if(32'h110, 32'h01100013);
      imem_req_ready = 1;
      c = 0;
      repeat (10) begin
         #2;
         if (imem_req_valid) c++;
         next();
      end
      #2;
      chk("dstall_accepts", c, 2);
      chk("dstall_if_valid", if_valid, 1);
      chk("dstall_if_pc", if_pc, 32'h108);
      chk("dstall_req_valid", imem_req_valid, 0);
      next();
      if_ready = 1;
      fetch_n(1);
      drain();
      // redirect with two requests in flight
      mem_hold = 1;
      fetch_n(2);
      redirect_valid = 1; redirect_addr = 32'h203;
      #2;
      chk("redir_load_en", pc_load_en, 1);
      chk("redir_load_addr", pc_load_addr, 32'h200);
      chk("redir_req_valid", imem_req_valid, 0);
      chk("redir_pc_inc", pc_inc, 0);
      next();
      redirect_valid = 0; mem_hold = 0;
      #2;
      chk("redir_load_en_off", pc_load_en, 0);
      next();
      expect_if(32'h200, 32'h02000013);
      fetch_n(1);
      drain();
      // redirect coincident with a response while an entry is buffered
      if_ready = 0; mem_hold = 1;
      fetch_n(1);
      mem_hold = 0;
      next();
      mem_hold = 1;
      next();
      fetch_n(1);
      if_ready = 1; redirect_valid = 1; redirect_addr = 32'h303; mem_hold = 0;
      #2;
      chk("redir_rsp_if_valid", if_valid, 0);
      chk("redir_rsp_load_addr", pc_load_addr, 32'h300);
      next();
      redirect_valid = 0;
      expect_if(32'h300, 32'h03000013);
      fetch_n(1);
      drain();
      // redirect coincident with a response, two outstanding
      mem_hold = 1;
      fetch_n(2);
      redirect_valid = 1; redirect_addr = 32'h400; mem_hold = 0;
      #2;
      chk("redir2_load_en", pc_load_en, 1);
      next();
      redirect_valid = 0;
      expect_if(32'h400, 32'h04000013);
      expect_if(32'h404, 32'h04040013);
      fetch_n(2);
      drain();
      // reset mid-flight; stale responses afterwards must be ignored
      mem_hold = 1;
      fetch_n(2);
      next();
      reset = 1; pc_in = 32'h502;
      repeat (2) begin
         #2;
         chk("mid_rst_if_valid", if_valid, 0);
         chk("mid_rst_req_valid", imem_req_valid, 0);
         next();
      end
      reset = 0; mem_hold = 0;
      #2;
      chk("align_req_addr", imem_req_addr, 32'h500);
      next();
      repeat (2) begin
         #2;
         chk("stale_if_valid", if_valid, 0);
         next();
      end
      expect_if(32'h500, 32'h05000013);
      expect_if(32'h504, 32'h05040013);
      fetch_n(2);
      drain();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
